fir: RTL and testbench

16-tap direct-form FIR filter with run-time programmable coefficients. It takes one 12-bit signed sample per enabled clock, forms the weighted sum of the last 16 samples, rescales it from Q11 coefficient format and drives a registered 16-bit signed result. It sits in the sample datapath between the ADC/sample source and downstream processing; coefficients are supplied as static inputs by the configuration logic.

---
 rtl/fir_pkg.sv | 28 ++
 rtl/fir_sat.sv | 31 +++
 rtl/fir.sv | 93 +++++++++
 tb/tb_fir.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared widths, types and helpers for the 16-tap FIR filter.
package fir_pkg;

  localparam int unsigned NTAPS      = 16;
  localparam int unsigned DATA_W     = 12;
  localparam int unsigned COEF_W     = 12;
  localparam int unsigned PROD_W     = DATA_W + COEF_W;
  localparam int unsigned OUT_W      = 16;
  localparam int unsigned ACC_W      = 28;
  localparam int unsigned FRAC_SHIFT = 11;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic signed [OUT_W-1:0]  out_t;

  localparam acc_t OUT_MAX = acc_t'(32767);
  localparam acc_t OUT_MIN = acc_t'(-32768);

  // Full-precision product, sign-extended to accumulator width.
  function automatic acc_t mac_term(sample_t x, coef_t c);
    prod_t p;
    p = prod_t'(x) * prod_t'(c);
    return acc_t'(p);
  endfunction

endpackage

// File: rtl/fir_sat.sv
// Rescales the Q11 accumulator to the 16-bit output.
// FIR_SATURATE_EN selects clamping; otherwise the result wraps.
module fir_sat
  import fir_pkg::*;
(
  input  acc_t acc,
  output out_t result
);

  acc_t shifted;

  // Arithmetic shift is floor division by 2^FRAC_SHIFT; no rounding.
  assign shifted = acc >>> FRAC_SHIFT;

`ifdef FIR_SATURATE_EN
  always_comb begin
    result = shifted[OUT_W-1:0];
    if (shifted > OUT_MAX) begin
      result = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (shifted < OUT_MIN) begin
      result = {1'b1, {(OUT_W-1){1'b0}}};
    end
  end
`else
  logic unused_hi;

  assign unused_hi = ^shifted[ACC_W-1:OUT_W];
  assign result    = shifted[OUT_W-1:0];
`endif

endmodule

// File: rtl/fir.sv
// 16-tap direct-form FIR with run-time coefficients and registered output.
// Output reduction is governed by FIR_SATURATE_EN (see fir_sat).
module fir
  import fir_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     control,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic signed [COEF_W-1:0] coef0,
  input  logic signed [COEF_W-1:0] coef1,
  input  logic signed [COEF_W-1:0] coef2,
  input  logic signed [COEF_W-1:0] coef3,
  input  logic signed [COEF_W-1:0] coef4,
  input  logic signed [COEF_W-1:0] coef5,
  input  logic signed [COEF_W-1:0] coef6,
  input  logic signed [COEF_W-1:0] coef7,
  input  logic signed [COEF_W-1:0] coef8,
  input  logic signed [COEF_W-1:0] coef9,
  input  logic signed [COEF_W-1:0] coef10,
  input  logic signed [COEF_W-1:0] coef11,
  input  logic signed [COEF_W-1:0] coef12,
  input  logic signed [COEF_W-1:0] coef13,
  input  logic signed [COEF_W-1:0] coef14,
  input  logic signed [COEF_W-1:0] coef15,
  output logic signed [OUT_W-1:0]  data_filt_o
);

  coef_t   coef  [NTAPS];
  sample_t x_q   [NTAPS];
  acc_t    term  [NTAPS];
  acc_t    acc;
  out_t    filt_d;
  out_t    filt_q;

  assign coef[0]  = coef0;
  assign coef[1]  = coef1;
  assign coef[2]  = coef2;
  assign coef[3]  = coef3;
  assign coef[4]  = coef4;
  assign coef[5]  = coef5;
  assign coef[6]  = coef6;
  assign coef[7]  = coef7;
  assign coef[8]  = coef8;
  assign coef[9]  = coef9;
  assign coef[10] = coef10;
  assign coef[11] = coef11;
  assign coef[12] = coef12;
  assign coef[13] = coef13;
  assign coef[14] = coef14;
  assign coef[15] = coef15;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NTAPS; k++) begin
        x_q[k] <= '0;
      end
    end else if (control) begin
      x_q[0] <= data_in;
      for (int k = 1; k < NTAPS; k++) begin
        x_q[k] <= x_q[k-1];
      end
    end
  end

  for (genvar k = 0; k < NTAPS; k++) begin : g_mac
    assign term[k] = mac_term(x_q[k], coef[k]);
  end

  // Sum is taken over the pre-shift delay line, so data_in lands one edge later.
  always_comb begin
    acc = '0;
    for (int k = 0; k < NTAPS; k++) begin
      acc = acc + term[k];
    end
  end

  fir_sat u_sat (
    .acc    (acc),
    .result (filt_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_q <= '0;
    end else if (control) begin
      filt_q <= filt_d;
    end
  end

  assign data_filt_o = filt_q;

endmodule

// File: tb/tb_fir.sv
// Directed self-checking bench for the fir filter.
module tb_fir;

  logic               clk;
  logic               rst;
  logic               control;
  logic signed [11:0] data_in;
  logic signed [11:0] c [16];
  logic signed [15:0] data_filt_o;

  int errors = 0;
  int checks = 0;

  fir dut (
    .clk         (clk),
    .rst         (rst),
    .control     (control),
    .data_in     (data_in),
    .coef0       (c[0]),
    .coef1       (c[1]),
    .coef2       (c[2]),
    .coef3       (c[3]),
    .coef4       (c[4]),
    .coef5       (c[5]),
    .coef6       (c[6]),
    .coef7       (c[7]),
    .coef8       (c[8]),
    .coef9       (c[9]),
    .coef10      (c[10]),
    .coef11      (c[11]),
    .coef12      (c[12]),
    .coef13      (c[13]),
    .coef14      (c[14]),
    .coef15      (c[15]),
    .data_filt_o (data_filt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int sym [16] = '{-99, 65, 136, 33, -156, -86, 376, 854,
                   854, 376, -86, -156, 33, 136, 65, -99};
  int imp [16] = '{-99, 64, 135, 32, -156, -86, 375, 853,
                   853, 375, -86, -156, 32, 135, 64, -99};

  initial begin
    logic [15:0] sat_exp;
`ifdef FIR_SATURATE_EN
    sat_exp = 16'h7FFF;
`else
    sat_exp = 16'h8000;
`endif

    for (int i = 0; i < 16; i++) c[i] = 12'(sym[i]);
    rst     = 1'b0;
    control = 1'b1;
    data_in = 12'h7FF;

    // Reset held while clocking with full-scale input.
    repeat (3) tick();
    check("reset_out", data_filt_o, 16'h0000);
    for (int i = 0; i < 16; i++) check($sformatf("reset_x%0d", i), 16'(dut.x_q[i]), 16'h0000);

    // Impulse, with a 5-cycle enable hold in the middle.
    rst     = 1'b1;
    data_in = 12'sd2047;
    tick();
    check("imp_first", data_filt_o, 16'h0000);
    data_in = 12'sd0;
    for (int i = 0; i < 16; i++) begin
      tick();
      check($sformatf("imp_%0d", i), data_filt_o, 16'(imp[i]));
      if (i == 5) begin
        control = 1'b0;
        data_in = 12'sd1000;
        for (int j = 0; j < 5; j++) begin
          tick();
          check($sformatf("hold_out_%0d", j), data_filt_o, 16'(imp[5]));
          check($sformatf("hold_x6_%0d", j), 16'(dut.x_q[6]), 16'(2047));
        end
        data_in = 12'sd0;
        control = 1'b1;
      end
    end
    tick();
    check("imp_tail", data_filt_o, 16'h0000);

    // Step of -1 settles to -2 after 17 enabled edges.
    data_in = 12'hFFF;
    tick();
    check("step_first", data_filt_o, 16'h0000);
    repeat (16) tick();
    check("step_settle", data_filt_o, 16'hFFFE);
    repeat (3) tick();
    check("step_stay", data_filt_o, 16'hFFFE);

    // Asynchronous reset between edges.
    #3;
    rst = 1'b0;
    #1;
    check("async_out", data_filt_o, 16'h0000);
    check("async_x0", 16'(dut.x_q[0]), 16'h0000);
    #2;
    rst = 1'b1;
    tick();
    check("post_reset", data_filt_o, 16'h0000);

    // Full-scale corner: k filled taps give k*2048, 16 taps overflow 16 bits.
    rst = 1'b0;
    for (int i = 0; i < 16; i++) c[i] = -12'sd2048;
    data_in = -12'sd2048;
    #2;
    rst = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("sat_ramp_%0d", k), data_filt_o, 16'((k - 1) * 2048));
    end
    tick();
    check("sat_full", data_filt_o, sat_exp);
    repeat (2) tick();
    check("sat_stay", data_filt_o, sat_exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
